// File: rtl/led_blink_scheduler_pkg.sv
// Shared types, defaults and the packed-bus field extractor for the LED blink scheduler.
package led_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ON   = 2'd1,
    OFF  = 2'd2,
    DONE = 2'd3
  } led_state_e;

  localparam int unsigned TICK_DIV_DFLT = 50_000_000;
  localparam int unsigned FIELD_BUS_W   = 256;
  localparam int unsigned FIELD_W_MAX   = 32;

  // Callers zero-extend their bus to FIELD_BUS_W and truncate the result to the field width.
  function automatic logic [FIELD_W_MAX-1:0] field_get(input logic [FIELD_BUS_W-1:0] bus,
                                                       input int unsigned idx,
                                                       input int unsigned w);
    logic [FIELD_BUS_W-1:0] mask;
    mask = ~({FIELD_BUS_W{1'b1}} << w);
    return FIELD_W_MAX'((bus >> (idx * w)) & mask);
  endfunction

endpackage

// File: rtl/led_blink_scheduler_if.sv
// Requester-side bundle of the LED blink scheduler: requests, pattern fields and status.
interface led_blink_scheduler_if #(
  parameter int unsigned N_REQ = 4,
  parameter int unsigned LEN_W = 8,
  parameter int unsigned REP_W = 8
);
  logic [N_REQ-1:0]       req;
  logic [N_REQ*LEN_W-1:0] on_len;
  logic [N_REQ*LEN_W-1:0] off_len;
  logic [N_REQ*REP_W-1:0] blink_cnt;
  logic [N_REQ-1:0]       grant;
  logic [N_REQ-1:0]       done;
  logic                   busy;
  logic                   led;

  modport master (output req, on_len, off_len, blink_cnt,
                  input  grant, done, busy, led);
  modport slave  (input  req, on_len, off_len, blink_cnt,
                  output grant, done, busy, led);
endinterface

// File: rtl/led_blink_scheduler_tick.sv
// Timing prescaler: one-cycle tick every TICK_DIV clocks, restartable with clr.
module led_tick_gen
  import led_pkg::*;
#(
  parameter int unsigned TICK_DIV = TICK_DIV_DFLT
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  output logic tick
);
  localparam int unsigned CNT_W = $clog2(TICK_DIV);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  assign tick = (cnt_q == CNT_W'(TICK_DIV - 1));

  always_comb begin
    cnt_d = cnt_q + 1'b1;
    if (clr || tick) cnt_d = '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end
endmodule

// File: rtl/led_blink_scheduler.sv
// Round-robin owner of one LED: latches a requester's blink pattern and plays it to completion.
module led_blink_scheduler
  import led_pkg::*;
#(
  parameter int unsigned N_REQ    = 4,
  parameter int unsigned TICK_DIV = TICK_DIV_DFLT,
  parameter int unsigned LEN_W    = 8,
  parameter int unsigned REP_W    = 8
) (
  input logic                  clk,
  input logic                  rst_n,
  led_blink_scheduler_if.slave io
);
  localparam int unsigned IDX_W = $clog2(N_REQ);

  led_state_e        state_q, state_d;
  logic [N_REQ-1:0]  grant_q, grant_d;
  logic [IDX_W-1:0]  owner_q, owner_d;
  logic [IDX_W-1:0]  rr_q, rr_d;
  logic [LEN_W-1:0]  on_q, on_d;
  logic [LEN_W-1:0]  off_q, off_d;
  logic [LEN_W-1:0]  phase_q, phase_d;
  logic [REP_W-1:0]  rep_q, rep_d;

  logic              tick;
  logic              clr;
  logic              win_vld;
  logic [IDX_W-1:0]  win_idx;
  logic [LEN_W-1:0]  on_sel, off_sel;
  logic [REP_W-1:0]  cnt_sel;

  function automatic logic [LEN_W-1:0] len_min1(input logic [LEN_W-1:0] v);
    return (v == '0) ? LEN_W'(1) : v;
  endfunction

  assign clr = !((state_q == ON) || (state_q == OFF));

  led_tick_gen #(.TICK_DIV(TICK_DIV)) u_tick (
    .clk  (clk),
    .rst_n(rst_n),
    .clr  (clr),
    .tick (tick)
  );

  // First asserted request at or above the rr pointer, wrapping.
  always_comb begin
    int unsigned      pos;
    logic [IDX_W-1:0] cand;
    win_vld = 1'b0;
    win_idx = '0;
    pos     = 0;
    cand    = '0;
    for (int unsigned k = 0; k < N_REQ; k++) begin
      pos  = (32'(rr_q) + k) % N_REQ;
      cand = IDX_W'(pos);
      if (!win_vld && io.req[cand]) begin
        win_vld = 1'b1;
        win_idx = cand;
      end
    end
  end

  assign on_sel  = LEN_W'(field_get(FIELD_BUS_W'(io.on_len),    32'(win_idx), LEN_W));
  assign off_sel = LEN_W'(field_get(FIELD_BUS_W'(io.off_len),   32'(win_idx), LEN_W));
  assign cnt_sel = REP_W'(field_get(FIELD_BUS_W'(io.blink_cnt), 32'(win_idx), REP_W));

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    owner_d = owner_q;
    rr_d    = rr_q;
    on_d    = on_q;
    off_d   = off_q;
    phase_d = phase_q;
    rep_d   = rep_q;
    unique case (state_q)
      IDLE: begin
        grant_d = '0;
        if (win_vld) begin
          grant_d = N_REQ'(1) << win_idx;
          owner_d = win_idx;
          rr_d    = (win_idx == IDX_W'(N_REQ - 1)) ? '0 : win_idx + 1'b1;
          on_d    = len_min1(on_sel);
          off_d   = len_min1(off_sel);
          phase_d = len_min1(on_sel);
          rep_d   = cnt_sel;
          state_d = (cnt_sel == '0) ? DONE : ON;
        end
      end
      ON: begin
        if (!io.req[owner_q]) begin
          state_d = IDLE;
          grant_d = '0;
        end else if (tick) begin
          if (phase_q == LEN_W'(1)) begin
            state_d = OFF;
            phase_d = off_q;
          end else begin
            phase_d = phase_q - 1'b1;
          end
        end
      end
      OFF: begin
        if (!io.req[owner_q]) begin
          state_d = IDLE;
          grant_d = '0;
        end else if (tick) begin
          if (phase_q == LEN_W'(1)) begin
            rep_d = rep_q - 1'b1;
            if (rep_q == REP_W'(1)) begin
              state_d = DONE;
            end else begin
              state_d = ON;
              phase_d = on_q;
            end
          end else begin
            phase_d = phase_q - 1'b1;
          end
        end
      end
      DONE: begin
        state_d = IDLE;
        grant_d = '0;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      grant_q <= '0;
      owner_q <= '0;
      rr_q    <= '0;
      on_q    <= '0;
      off_q   <= '0;
      phase_q <= '0;
      rep_q   <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      owner_q <= owner_d;
      rr_q    <= rr_d;
      on_q    <= on_d;
      off_q   <= off_d;
      phase_q <= phase_d;
      rep_q   <= rep_d;
    end
  end

  assign io.grant = grant_q;
  assign io.done  = (state_q == DONE) ? grant_q : '0;
  assign io.busy  = (state_q != IDLE);
  assign io.led   = (state_q == ON);
endmodule

// File: tb/tb_led_blink_scheduler.sv
// Directed scenarios plus randomized traffic against a service-timeline model of the LED scheduler.
module tb_led_blink_scheduler;
  localparam int TD = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  led_blink_scheduler_if #(.N_REQ(4), .LEN_W(8), .REP_W(8)) bus ();

  led_blink_scheduler #(.N_REQ(4), .TICK_DIV(TD), .LEN_W(8), .REP_W(8)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .io   (bus.slave)
  );

  int n_tests = 0;
  int n_fail  = 0;

  int on_f [4];
  int off_f[4];
  int cnt_f[4];

  // Model: a service is a start point plus elapsed cycles; outputs follow from arithmetic on that.
  int m_busy, m_owner, m_k, m_on, m_off, m_cnt, m_rr;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int clamp1(input int v);
    return (v == 0) ? 1 : v;
  endfunction

  task automatic model_reset();
    m_busy = 0; m_owner = 0; m_k = 0; m_on = 0; m_off = 0; m_cnt = 0; m_rr = 0;
  endtask

  task automatic model_exp(output logic [3:0] g, output logic [3:0] d,
                           output logic b, output logic l);
    int t;
    g = '0; d = '0; b = 1'b0; l = 1'b0;
    if (m_busy != 0) begin
      t = m_cnt * (m_on + m_off) * TD;
      g = 4'(1 << m_owner);
      b = 1'b1;
      if (m_k <= t) l = (((m_k - 1) % ((m_on + m_off) * TD)) < (m_on * TD));
      else          d = g;
    end
  endtask

  task automatic model_step();
    int t;
    int i;
    int found;
    if (m_busy == 0) begin
      found = 0;
      for (int k = 0; k < 4; k++) begin
        i = (m_rr + k) % 4;
        if (found == 0 && bus.req[2'(i)]) begin
          found   = 1;
          m_busy  = 1;
          m_owner = i;
          m_k     = 1;
          m_on    = clamp1(on_f[i]);
          m_off   = clamp1(off_f[i]);
          m_cnt   = cnt_f[i];
          m_rr    = (i + 1) % 4;
        end
      end
    end else begin
      t = m_cnt * (m_on + m_off) * TD;
      if (m_k == t + 1)                 m_busy = 0;
      else if (!bus.req[2'(m_owner)])   m_busy = 0;
      else                              m_k++;
    end
  endtask

  task automatic drive_fields();
    bus.on_len    = {8'(on_f[3]),  8'(on_f[2]),  8'(on_f[1]),  8'(on_f[0])};
    bus.off_len   = {8'(off_f[3]), 8'(off_f[2]), 8'(off_f[1]), 8'(off_f[0])};
    bus.blink_cnt = {8'(cnt_f[3]), 8'(cnt_f[2]), 8'(cnt_f[1]), 8'(cnt_f[0])};
  endtask

  task automatic set_req(input int i, input int on, input int off, input int cnt);
    on_f[i] = on; off_f[i] = off; cnt_f[i] = cnt;
    drive_fields();
    bus.req[2'(i)] = 1'b1;
  endtask

  task automatic check_outputs_zero(input string tag);
    check_val({tag, "_grant"}, 32'(bus.grant), 32'h0);
    check_val({tag, "_done"},  32'(bus.done),  32'h0);
    check_val({tag, "_busy"},  32'(bus.busy),  32'h0);
    check_val({tag, "_led"},   32'(bus.led),   32'h0);
  endtask

  // One clock: model advances on the inputs seen at the edge, outputs checked on the falling edge.
  task automatic tick_check();
    logic [3:0] g, d;
    logic b, l;
    @(posedge clk);
    model_step();
    @(negedge clk);
    model_exp(g, d, b, l);
    check_val("mdl_grant", 32'(bus.grant), 32'(g));
    check_val("mdl_done",  32'(bus.done),  32'(d));
    check_val("mdl_busy",  32'(bus.busy),  32'(b));
    check_val("mdl_led",   32'(bus.led),   32'(l));
  endtask

  task automatic do_reset();
    bus.req = '0;
    rst_n = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
  endtask

  initial begin
    logic [3:0] g, d;
    logic b, l;
    logic [3:0] rr_seq[$];
    logic [3:0] prev_g;

    model_reset();
    for (int i = 0; i < 4; i++) begin on_f[i] = 1; off_f[i] = 1; cnt_f[i] = 0; end
    drive_fields();
    bus.req = 4'b1111;

    // Reset defaults with all requests pending
    @(negedge clk);
    @(negedge clk);
    check_outputs_zero("rst");
    rst_n = 1'b1;
    tick_check();
    check_val("rst_first_grant", 32'(bus.grant), 32'h1);
    bus.req = '0;
    tick_check();

    // Basic pattern on=2 off=1 cnt=2
    do_reset();
    set_req(0, 2, 1, 2);
    for (int n = 1; n <= 26; n++) begin
      tick_check();
      check_val("basic_led", 32'(bus.led), 32'(((n >= 1 && n <= 8) || (n >= 13 && n <= 20)) ? 1 : 0));
      if (n == 25) begin
        check_val("basic_done", 32'(bus.done), 32'h1);
        bus.req = '0;
      end
      if (n == 26) begin
        check_val("basic_idle_grant", 32'(bus.grant), 32'h0);
        check_val("basic_idle_busy",  32'(bus.busy),  32'h0);
      end
    end

    // Round robin with 1011 held
    do_reset();
    for (int i = 0; i < 4; i++) begin on_f[i] = 1; off_f[i] = 1; cnt_f[i] = 1; end
    drive_fields();
    bus.req = 4'b1011;
    prev_g = '0;
    for (int n = 0; n < 40; n++) begin
      tick_check();
      if (prev_g == 4'b0 && bus.grant != 4'b0) rr_seq.push_back(bus.grant);
      prev_g = bus.grant;
    end
    bus.req = '0;
    tick_check();
    check_val("rr_count", 32'(rr_seq.size()), 32'd4);
    if (rr_seq.size() == 4) begin
      check_val("rr_g0", 32'(rr_seq[0]), 32'b0001);
      check_val("rr_g1", 32'(rr_seq[1]), 32'b0010);
      check_val("rr_g2", 32'(rr_seq[2]), 32'b1000);
      check_val("rr_g3", 32'(rr_seq[3]), 32'b0001);
    end

    // Zero count, then zero lengths
    set_req(1, 3, 3, 0);
    tick_check();
    check_val("cnt0_done", 32'(bus.done), 32'b0010);
    check_val("cnt0_led",  32'(bus.led),  32'h0);
    bus.req = '0;
    tick_check();
    set_req(1, 0, 0, 1);
    for (int n = 1; n <= 10; n++) begin
      tick_check();
      check_val("len0_led",  32'(bus.led),  32'((n <= 4) ? 1 : 0));
      check_val("len0_done", 32'(bus.done), 32'((n == 9) ? 4'b0010 : 4'b0000));
      if (n == 9) bus.req = '0;
    end

    // Abort owner 2 mid-ON while 3 waits
    set_req(2, 3, 3, 2);
    tick_check();
    set_req(3, 1, 1, 1);
    tick_check();
    tick_check();
    bus.req[2] = 1'b0;
    tick_check();
    check_outputs_zero("abort");
    tick_check();
    check_val("abort_next_grant", 32'(bus.grant), 32'b1000);
    bus.req = '0;
    tick_check();

    // Asynchronous reset in the OFF phase
    set_req(0, 1, 2, 1);
    for (int n = 1; n <= 6; n++) tick_check();
    check_val("ar_pre_busy", 32'(bus.busy), 32'h1);
    #2 rst_n = 1'b0;
    #1 check_outputs_zero("async_rst");
    model_reset();
    @(negedge clk);
    check_outputs_zero("async_rst_hold");
    rst_n = 1'b1;
    for (int n = 1; n <= 14; n++) begin
      tick_check();
      if (n == 1) begin
        check_val("ar_restart_grant", 32'(bus.grant), 32'h1);
        check_val("ar_restart_led",   32'(bus.led),   32'h1);
      end
      if (n == 13) begin
        check_val("ar_done", 32'(bus.done), 32'h1);
        bus.req = '0;
      end
    end

    // Randomized traffic
    for (int n = 0; n < 3000; n++) begin
      tick_check();
      model_exp(g, d, b, l);
      for (int i = 0; i < 4; i++) begin
        if (!bus.req[2'(i)]) begin
          if ($urandom_range(7, 0) == 0)
            set_req(i, int'($urandom_range(3, 0)), int'($urandom_range(3, 0)), int'($urandom_range(3, 0)));
        end else if (d[2'(i)]) begin
          if ($urandom_range(3, 0) != 0) bus.req[2'(i)] = 1'b0;
        end else if ($urandom_range(199, 0) == 0) begin
          bus.req[2'(i)] = 1'b0;
        end
      end
    end
    bus.req = '0;
    for (int n = 0; n < 4; n++) tick_check();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
